// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Brief    : Shared encodings for the RV32IM execute stage.
// Revision : 1.0
// ============================================================================
package rv_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_if
// Brief    : Decode/hazard-side inputs and E->M outputs of the execute stage.
// Revision : 1.0
// ============================================================================
interface execute_stage_if;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]  RdE;
    logic [3:0]  ALUControlE;
    logic        ALUSrcE, MulDivE, BranchE, JumpE, JalrE, RegWriteE, MemWriteE;
    logic [2:0]  MulDivOpE, BranchOpE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic        PCSrcE, BusyE, MemWriteM, RegWriteM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic [1:0]  ResultSrcM;

    modport master (
        output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, ALUControlE, ALUSrcE,
               MulDivE, MulDivOpE, BranchE, BranchOpE, JumpE, JalrE, RegWriteE,
               MemWriteE, ResultSrcE, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, BusyE, ALUResultM, WriteDataM, RdM, PCPlus4M,
               MemWriteM, RegWriteM, ResultSrcM
    );

    modport slave (
        input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, ALUControlE, ALUSrcE,
               MulDivE, MulDivOpE, BranchE, BranchOpE, JumpE, JalrE, RegWriteE,
               MemWriteE, ResultSrcE, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, BusyE, ALUResultM, WriteDataM, RdM, PCPlus4M,
               MemWriteM, RegWriteM, ResultSrcM
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Brief    : Iterative shift-add multiplier / restoring divider (RV32M).
// Revision : 1.0
// ============================================================================
module muldiv_iter
    import rv_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_start,
    input  wire logic [2:0]  i_op,
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [31:0]      o_result
);
    localparam int CNT_W = $clog2(MD_CYCLES);

    md_state_t        r_state, w_nextState;
    logic [CNT_W-1:0] r_count;
    logic [63:0]      r_acc;
    logic [31:0]      r_opnd;
    logic [2:0]       r_op;
    logic             r_negA, r_negB, r_divZero;

    // Operands are reduced to magnitudes; signs are re-applied at DONE.
    logic        w_aSigned, w_bSigned, w_negA, w_negB;
    logic [31:0] w_magA, w_magB;
    assign w_aSigned = (i_op == MD_MULH) || (i_op == MD_MULHSU) || (i_op == MD_DIV) || (i_op == MD_REM);
    assign w_bSigned = (i_op == MD_MULH) || (i_op == MD_DIV) || (i_op == MD_REM);
    assign w_negA    = w_aSigned & i_a[31];
    assign w_negB    = w_bSigned & i_b[31];
    assign w_magA    = w_negA ? (~i_a + 32'd1) : i_a;
    assign w_magB    = w_negB ? (~i_b + 32'd1) : i_b;

    logic [32:0] w_mulSum, w_divShift;
    logic [63:0] w_mulNext, w_divNext;
    logic [31:0] w_divDiff;
    logic        w_divGe;
    assign w_mulSum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mulNext  = {w_mulSum, r_acc[31:1]};
    assign w_divShift = r_acc[63:31];
    assign w_divGe    = w_divShift >= {1'b0, r_opnd};
    assign w_divDiff  = w_divShift[31:0] - r_opnd;
    assign w_divNext  = w_divGe ? {w_divDiff, r_acc[30:0], 1'b1}
                                : {w_divShift[31:0], r_acc[30:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_nextState = S_RUN;
            S_RUN:   if (r_count == CNT_W'(MD_CYCLES - 1)) w_nextState = S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_IDLE:  o_busy = i_start;
            S_RUN:   o_busy = 1'b1;
            S_DONE:  o_done = 1'b1;
            default: o_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_op      <= '0;
            r_negA    <= 1'b0;
            r_negB    <= 1'b0;
            r_divZero <= 1'b0;
        end else if (r_state == S_IDLE && i_start) begin
            r_count   <= '0;
            r_acc     <= {32'd0, w_magA};
            r_opnd    <= w_magB;
            r_op      <= i_op;
            r_negA    <= w_negA;
            r_negB    <= w_negB;
            r_divZero <= (i_b == 32'd0);
        end else if (r_state == S_RUN) begin
            r_count <= r_count + CNT_W'(1);
            r_acc   <= r_op[2] ? w_divNext : w_mulNext;
        end
    end

    logic [63:0] w_prod;
    logic [31:0] w_quot, w_rem;
    assign w_prod = (r_negA ^ r_negB) ? (~r_acc + 64'd1) : r_acc;
    assign w_quot = (r_negA ^ r_negB) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem  = r_negA ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_comb begin
        o_result = w_prod[31:0];
        case (r_op)
            MD_MUL:                      o_result = w_prod[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod[63:32];
            MD_DIV, MD_DIVU:             o_result = r_divZero ? 32'hFFFF_FFFF : w_quot;
            MD_REM, MD_REMU:             o_result = w_rem;
            default:                     o_result = w_prod[31:0];
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/reg_rst_param.sv
`default_nettype none
// ============================================================================
// Module   : reg_rst_param
// Brief    : Parameterised-width register with synchronous clear.
// Revision : 1.0
// ============================================================================
module reg_rst_param #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);
    always_ff @(posedge clk) begin
        if (rst) o_q <= '0;
        else     o_q <= i_d;
    end
endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Brief    : RV32IM execute stage: forwarding, ALU, branch, mul/div, E->M reg.
// Revision : 1.0
// ============================================================================
module execute_stage
    import rv_pkg::*;
#(
    parameter bit MULDIV_EN = 1'b1,
    parameter int MD_CYCLES = 32
) (
    input wire logic        clk,
    input wire logic        rst,
    execute_stage_if.slave  bus
);
    logic [31:0] w_srcA, w_fwdB, w_srcB, w_aluResult, w_mdResult, w_jalrSum;
    logic [3:0]  w_aluOp;
    logic [4:0]  w_shamt;
    logic        w_cond, w_mdBusy, w_mdDone, w_flush;

    always_comb begin
        case (bus.ForwardAE)
            FWD_MEM: w_srcA = bus.ALUResultM;
            FWD_WB:  w_srcA = bus.ResultW;
            default: w_srcA = bus.RD1E;
        endcase
        case (bus.ForwardBE)
            FWD_MEM: w_fwdB = bus.ALUResultM;
            FWD_WB:  w_fwdB = bus.ResultW;
            default: w_fwdB = bus.RD2E;
        endcase
    end
    assign w_srcB  = bus.ALUSrcE ? bus.ImmExtE : w_fwdB;
    assign w_shamt = w_srcB[4:0];
    assign w_aluOp = bus.MulDivE ? ALU_ADD : bus.ALUControlE;

    always_comb begin
        case (w_aluOp)
            ALU_SUB:  w_aluResult = w_srcA - w_srcB;
            ALU_AND:  w_aluResult = w_srcA & w_srcB;
            ALU_OR:   w_aluResult = w_srcA | w_srcB;
            ALU_XOR:  w_aluResult = w_srcA ^ w_srcB;
            ALU_SLT:  w_aluResult = {31'd0, $signed(w_srcA) < $signed(w_srcB)};
            ALU_SLTU: w_aluResult = {31'd0, w_srcA < w_srcB};
            ALU_SLL:  w_aluResult = w_srcA << w_shamt;
            ALU_SRL:  w_aluResult = w_srcA >> w_shamt;
            ALU_SRA:  w_aluResult = $signed(w_srcA) >>> w_shamt;
            default:  w_aluResult = w_srcA + w_srcB;
        endcase
    end

    // Branch compare uses forwarded rs2, never the immediate-muxed SrcB.
    always_comb begin
        case (bus.BranchOpE)
            BR_BEQ:  w_cond = (w_srcA == w_fwdB);
            BR_BNE:  w_cond = (w_srcA != w_fwdB);
            BR_BLT:  w_cond = ($signed(w_srcA) < $signed(w_fwdB));
            BR_BGE:  w_cond = ($signed(w_srcA) >= $signed(w_fwdB));
            BR_BLTU: w_cond = (w_srcA < w_fwdB);
            BR_BGEU: w_cond = (w_srcA >= w_fwdB);
            default: w_cond = 1'b0;
        endcase
    end
    assign w_jalrSum     = w_srcA + bus.ImmExtE;
    assign bus.PCSrcE    = bus.JumpE | (bus.BranchE & w_cond);
    assign bus.PCTargetE = bus.JalrE ? {w_jalrSum[31:1], 1'b0} : (bus.PCE + bus.ImmExtE);

    if (MULDIV_EN) begin : g_muldiv
        muldiv_iter #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
            .clk      (clk),
            .rst      (rst),
            .i_start  (bus.MulDivE),
            .i_op     (bus.MulDivOpE),
            .i_a      (w_srcA),
            .i_b      (w_fwdB),
            .o_busy   (w_mdBusy),
            .o_done   (w_mdDone),
            .o_result (w_mdResult)
        );
    end else begin : g_noMuldiv
        assign w_mdBusy   = 1'b0;
        assign w_mdDone   = 1'b0;
        assign w_mdResult = 32'd0;
    end
    assign bus.BusyE = w_mdBusy;

    // Control fields of the mul/div instruction, replayed into M at DONE.
    logic [4:0]  r_mdRd;
    logic [31:0] r_mdPcPlus4;
    logic [1:0]  r_mdResultSrc;
    logic        r_mdRegWrite;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mdRd        <= '0;
            r_mdPcPlus4   <= '0;
            r_mdResultSrc <= '0;
            r_mdRegWrite  <= 1'b0;
        end else if (w_mdBusy) begin
            r_mdRd        <= bus.RdE;
            r_mdPcPlus4   <= bus.PCPlus4E;
            r_mdResultSrc <= bus.ResultSrcE;
            r_mdRegWrite  <= bus.RegWriteE;
        end
    end

    assign w_flush = rst | w_mdBusy;

    reg_rst_param #(.WIDTH(32)) u_aluResultM (.clk(clk), .rst(w_flush),
        .i_d(w_mdDone ? w_mdResult : w_aluResult), .o_q(bus.ALUResultM));
    reg_rst_param #(.WIDTH(32)) u_writeDataM (.clk(clk), .rst(w_flush),
        .i_d(w_mdDone ? 32'd0 : w_fwdB), .o_q(bus.WriteDataM));
    reg_rst_param #(.WIDTH(5)) u_rdM (.clk(clk), .rst(w_flush),
        .i_d(w_mdDone ? r_mdRd : bus.RdE), .o_q(bus.RdM));
    reg_rst_param #(.WIDTH(32)) u_pcPlus4M (.clk(clk), .rst(w_flush),
        .i_d(w_mdDone ? r_mdPcPlus4 : bus.PCPlus4E), .o_q(bus.PCPlus4M));
    reg_rst_param #(.WIDTH(1)) u_memWriteM (.clk(clk), .rst(w_flush),
        .i_d(w_mdDone ? 1'b0 : bus.MemWriteE), .o_q(bus.MemWriteM));
    reg_rst_param #(.WIDTH(1)) u_regWriteM (.clk(clk), .rst(w_flush),
        .i_d(w_mdDone ? r_mdRegWrite : bus.RegWriteE), .o_q(bus.RegWriteM));
    reg_rst_param #(.WIDTH(2)) u_resultSrcM (.clk(clk), .rst(w_flush),
        .i_d(w_mdDone ? r_mdResultSrc : bus.ResultSrcE), .o_q(bus.ResultSrcM));
endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Brief    : Directed self-checking bench for execute_stage.
// Revision : 1.0
// ============================================================================
module tb_execute_stage;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    execute_stage_if bus ();

    execute_stage #(.MULDIV_EN(1'b1), .MD_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        bus.RD1E = 0; bus.RD2E = 0; bus.ImmExtE = 0; bus.PCE = 0; bus.PCPlus4E = 0;
        bus.ResultW = 0; bus.RdE = 0; bus.ALUControlE = ALU_ADD; bus.ALUSrcE = 0;
        bus.MulDivE = 0; bus.MulDivOpE = 0; bus.BranchE = 0; bus.BranchOpE = 0;
        bus.JumpE = 0; bus.JalrE = 0; bus.RegWriteE = 0; bus.MemWriteE = 0;
        bus.ResultSrcE = 0; bus.ForwardAE = FWD_RF; bus.ForwardBE = FWD_RF;
    endtask

    task automatic runAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input string tag);
        clearInputs();
        bus.ALUControlE = op; bus.RD1E = a; bus.RD2E = b; bus.RdE = rd; bus.RegWriteE = 1;
        @(posedge clk); #1;
        checkVal(tag, bus.ALUResultM, exp);
        checkVal({tag, "_rd"}, {27'd0, bus.RdM}, {27'd0, rd});
    endtask

    task automatic runMd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        int busyCnt;
        clearInputs();
        bus.MulDivE = 1; bus.MulDivOpE = op; bus.RD1E = a; bus.RD2E = b;
        bus.RdE = 5'd9; bus.RegWriteE = 1; bus.PCPlus4E = 32'h204; bus.ResultSrcE = 2'd1;
        #1;
        busyCnt = bus.BusyE ? 1 : 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                checkVal({tag, "_bubbleRegWr"}, {31'd0, bus.RegWriteM}, 32'd0);
                checkVal({tag, "_bubbleRd"}, {27'd0, bus.RdM}, 32'd0);
            end
            if (!bus.BusyE) break;
            busyCnt++;
        end
        clearInputs();
        @(posedge clk); #1;
        checkVal({tag, "_busyCycles"}, busyCnt, 32'd33);
        checkVal(tag, bus.ALUResultM, exp);
        checkVal({tag, "_rd"}, {27'd0, bus.RdM}, 32'd9);
        checkVal({tag, "_regWr"}, {31'd0, bus.RegWriteM}, 32'd1);
        checkVal({tag, "_pc4"}, bus.PCPlus4M, 32'h204);
        checkVal({tag, "_resSrc"}, {30'd0, bus.ResultSrcM}, 32'd1);
    endtask

    task automatic checkMZero(input string tag);
        checkVal({tag, "_alu"}, bus.ALUResultM, 32'd0);
        checkVal({tag, "_wd"}, bus.WriteDataM, 32'd0);
        checkVal({tag, "_rd"}, {27'd0, bus.RdM}, 32'd0);
        checkVal({tag, "_pc4"}, bus.PCPlus4M, 32'd0);
        checkVal({tag, "_ctl"}, {28'd0, bus.MemWriteM, bus.RegWriteM, bus.ResultSrcM}, 32'd0);
        checkVal({tag, "_busy"}, {31'd0, bus.BusyE}, 32'd0);
    endtask

    initial begin
        clearInputs();
        bus.RD1E = 32'h1234; bus.RegWriteE = 1; bus.RdE = 5'd7;
        repeat (2) @(posedge clk);
        #1;
        checkMZero("reset");
        rst = 0;

        // Basic ALU
        runAlu(ALU_ADD, 32'd5, 32'd7, 5'd3, 32'd12, "add");
        checkVal("add_regWr", {31'd0, bus.RegWriteM}, 32'd1);
        checkVal("add_busy", {31'd0, bus.BusyE}, 32'd0);
        runAlu(ALU_SUB, 32'd5, 32'd7, 5'd4, 32'hFFFF_FFFE, "sub");
        runAlu(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd1, "slt");
        runAlu(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd0, "sltu");
        runAlu(ALU_SRA, 32'h8000_0000, 32'h0000_0024, 5'd6, 32'hF800_0000, "sra");
        runAlu(ALU_SRL, 32'h8000_0000, 32'h0000_0024, 5'd6, 32'h0800_0000, "srl");
        runAlu(ALU_SLL, 32'h0000_0003, 32'h0000_0021, 5'd6, 32'h0000_0006, "sll");
        runAlu(ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd2, 32'h0FF0_0FF0, "xor");
        runAlu(4'd12, 32'd10, 32'd20, 5'd2, 32'd30, "undefAdd");

        // Forwarding
        runAlu(ALU_ADD, 32'd8, 32'd8, 5'd1, 32'h10, "fwdSetup");
        clearInputs();
        bus.ForwardAE = FWD_MEM; bus.RD1E = 32'hDEAD; bus.ImmExtE = 32'd4; bus.ALUSrcE = 1;
        @(posedge clk); #1;
        checkVal("fwdMem", bus.ALUResultM, 32'h14);
        bus.ForwardAE = FWD_WB; bus.ResultW = 32'h100;
        @(posedge clk); #1;
        checkVal("fwdWb", bus.ALUResultM, 32'h104);
        bus.ForwardAE = 2'b11; bus.RD1E = 32'h20;
        @(posedge clk); #1;
        checkVal("fwd11", bus.ALUResultM, 32'h24);
        bus.ForwardAE = FWD_RF; bus.RD1E = 32'd1; bus.ALUSrcE = 0; bus.ForwardBE = FWD_MEM;
        bus.MemWriteE = 1;
        @(posedge clk); #1;
        checkVal("fwdB_alu", bus.ALUResultM, 32'h25);
        checkVal("fwdB_wd", bus.WriteDataM, 32'h24);
        checkVal("fwdB_mw", {31'd0, bus.MemWriteM}, 32'd1);

        // Branch / jump (combinational); SrcB holds the immediate, not rs2
        clearInputs();
        bus.BranchE = 1; bus.BranchOpE = BR_BLT; bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 32'd1;
        bus.PCE = 32'h40; bus.ImmExtE = 32'h10; bus.ALUSrcE = 1;
        #1;
        checkVal("blt_src", {31'd0, bus.PCSrcE}, 32'd1);
        checkVal("blt_tgt", bus.PCTargetE, 32'h50);
        bus.BranchOpE = BR_BLTU; #1;
        checkVal("bltu_src", {31'd0, bus.PCSrcE}, 32'd0);
        bus.BranchOpE = BR_BNE; #1;
        checkVal("bne_src", {31'd0, bus.PCSrcE}, 32'd1);
        bus.BranchOpE = BR_BEQ; bus.RD2E = 32'hFFFF_FFFF; #1;
        checkVal("beq_src", {31'd0, bus.PCSrcE}, 32'd1);
        bus.BranchE = 0; bus.JumpE = 1; bus.JalrE = 1; bus.RD1E = 32'h103; #1;
        checkVal("jalr_src", {31'd0, bus.PCSrcE}, 32'd1);
        checkVal("jalr_tgt", bus.PCTargetE, 32'h112);
        @(posedge clk); #1;

        // Multiply / divide
        runMd(MD_MUL,   32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, "mul");
        runMd(MD_MULHU, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002, "mulhu");
        runMd(MD_MULH,  32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, "mulh");
        runMd(MD_DIV,   32'd7, 32'd0, 32'hFFFF_FFFF, "div0");
        runMd(MD_REM,   32'd7, 32'd0, 32'd7, "rem0");
        runMd(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "divOvf");
        runMd(MD_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "remOvf");
        runMd(MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "divNeg");
        runMd(MD_REM,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "remNeg");
        runMd(MD_DIVU,  32'd100, 32'd7, 32'd14, "divu");

        // Reset during RUN with counter=10
        clearInputs();
        bus.MulDivE = 1; bus.MulDivOpE = MD_MUL; bus.RD1E = 32'd5; bus.RD2E = 32'd6;
        bus.RdE = 5'd8; bus.RegWriteE = 1;
        repeat (11) @(posedge clk);
        #1;
        checkVal("midRun_busy", {31'd0, bus.BusyE}, 32'd1);
        clearInputs();
        rst = 1;
        @(posedge clk); #1;
        checkMZero("midRst");
        rst = 0;
        runAlu(ALU_ADD, 32'd1, 32'd2, 5'd4, 32'd3, "postRstAdd");
        checkVal("postRst_busy", {31'd0, bus.BusyE}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
